// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer
// Initiator-side controller for the 16x8 calculator register file.
// Takes one register-to-register command, reads its operands through the
// file's two asynchronous read ports, runs an 8-bit ALU operation, writes the
// result back to rd and returns the result with carry/zero flags.
//
// The register file has no write enable and writes on every negedge of nclk.
// Outside an active write, the write port is therefore pointed at read port A
// with the data taken straight from rf_out_A. Each negedge then rewrites a
// register with its own unchanged value.

module reg_op_sequencer #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          nclk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic [W-1:0]  cmd_imm,
    output logic [AW-1:0] rf_address_A,
    output logic [AW-1:0] rf_address_B,
    output logic [AW-1:0] rf_address_D,
    output logic [W-1:0]  rf_data_in,
    input  logic [W-1:0]  rf_out_A,
    input  logic [W-1:0]  rf_out_B,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_data,
    output logic          rsp_carry,
    output logic          rsp_zero,
    output logic          busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_ADDI = 3'd5;
    localparam logic [2:0] OP_LDI  = 3'd6;
    localparam logic [2:0] OP_NOP  = 3'd7;

    logic [2:0]    state;
    logic [2:0]    next_state;
    logic          accept;
    logic [2:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [W-1:0]  imm_q;
    logic [W-1:0]  opa_q;
    logic [W-1:0]  opb_q;
    logic [W-1:0]  result_q;
    logic          carry_q;
    logic          zero_q;
    logic [W:0]    alu_full;
    logic          write_phase;
    logic [AW-1:0] addr_a_next;
    logic [AW-1:0] addr_d_next;

    assign accept = cmd_valid && cmd_ready;

    // Next-state decode for the five-step command sequence
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = S_READ;
            S_READ:  next_state = S_EXEC;
            S_EXEC:  next_state = S_WRITE;
            S_WRITE: next_state = S_DONE;
            S_DONE:  if (rsp_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State register plus registered handshake/status outputs decoded from the next state
    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= next_state;
            cmd_ready <= (next_state == S_IDLE);
            busy      <= (next_state != S_IDLE);
            rsp_valid <= (next_state == S_DONE);
        end
    end

    // Latch the command fields on the accepting edge; they stay put for the whole command
    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            op_q  <= OP_NOP;
            rd_q  <= '0;
            imm_q <= '0;
        end else if (accept) begin
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            imm_q <= cmd_imm;
        end
    end

    // Read-port A only moves on accept; write port targets rd only for a real write
    always_comb begin
        addr_a_next = accept ? cmd_rs1 : rf_address_A;
        addr_d_next = addr_a_next;
        if ((next_state == S_WRITE) && (op_q != OP_NOP)) begin
            addr_d_next = rd_q;
        end
    end

    // Registered register-file addresses
    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            rf_address_A <= '0;
            rf_address_B <= '0;
            rf_address_D <= '0;
        end else begin
            rf_address_A <= addr_a_next;
            if (accept) begin
                rf_address_B <= cmd_rs2;
            end
            rf_address_D <= addr_d_next;
        end
    end

    // Capture both operands from the asynchronous read ports at the end of READ
    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            opa_q <= '0;
            opb_q <= '0;
        end else if (state == S_READ) begin
            opa_q <= rf_out_A;
            opb_q <= rf_out_B;
        end
    end

    // ALU: 9-bit result whose top bit is carry for adds and borrow for SUB
    always_comb begin
        alu_full = {1'b0, opa_q};
        case (op_q)
            OP_ADD:  alu_full = {1'b0, opa_q} + {1'b0, opb_q};
            OP_SUB:  alu_full = {1'b0, opa_q} - {1'b0, opb_q};
            OP_AND:  alu_full = {1'b0, opa_q & opb_q};
            OP_OR:   alu_full = {1'b0, opa_q | opb_q};
            OP_XOR:  alu_full = {1'b0, opa_q ^ opb_q};
            OP_ADDI: alu_full = {1'b0, opa_q} + {1'b0, imm_q};
            OP_LDI:  alu_full = {1'b0, imm_q};
            default: alu_full = {1'b0, opa_q};
        endcase
    end

    // Register the ALU result and flags at the end of EXEC; they back the response outputs
    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else if (state == S_EXEC) begin
            result_q <= alu_full[W-1:0];
            carry_q  <= alu_full[W];
            zero_q   <= (alu_full[W-1:0] == '0);
        end
    end

    // Reset forces state to IDLE immediately, so a write is aborted before its negedge
    assign write_phase = (state == S_WRITE) && (op_q != OP_NOP);
    assign rf_data_in  = write_phase ? result_q : rf_out_A;

    assign rsp_data  = result_q;
    assign rsp_carry = carry_q;
    assign rsp_zero  = zero_q;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// tb_reg_op_sequencer
// Directed and random commands for reg_op_sequencer against a behavioural
// 16x8 register file and a golden copy of the register contents.

module tb_reg_op_sequencer;

    logic       nclk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_rd;
    logic [3:0] cmd_rs1;
    logic [3:0] cmd_rs2;
    logic [7:0] cmd_imm;
    logic [3:0] rf_address_A;
    logic [3:0] rf_address_B;
    logic [3:0] rf_address_D;
    logic [7:0] rf_data_in;
    logic [7:0] rf_out_A;
    logic [7:0] rf_out_B;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rf [16];
    logic [7:0] exp_rf [16];
    logic       rf_loaded = 1'b0;

    logic       watch_en = 1'b0;
    logic [3:0] watch_addr = 4'd0;
    int         raw_writes = 0;
    int         change_writes = 0;

    reg_op_sequencer #(.W(8), .AW(4)) dut (
        .nclk         (nclk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_rd       (cmd_rd),
        .cmd_rs1      (cmd_rs1),
        .cmd_rs2      (cmd_rs2),
        .cmd_imm      (cmd_imm),
        .rf_address_A (rf_address_A),
        .rf_address_B (rf_address_B),
        .rf_address_D (rf_address_D),
        .rf_data_in   (rf_data_in),
        .rf_out_A     (rf_out_A),
        .rf_out_B     (rf_out_B),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_carry    (rsp_carry),
        .rsp_zero     (rsp_zero),
        .busy         (busy)
    );

    always #5 nclk = ~nclk;

    // Register file: asynchronous reads, unconditional write on every negedge
    assign rf_out_A = rf[rf_address_A];
    assign rf_out_B = rf[rf_address_B];

    always @(negedge nclk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'(i);
            rf_loaded <= 1'b1;
        end else begin
            rf[rf_address_D] <= rf_data_in;
        end
    end

    // Count writes aimed at the watched register, and those that change its value
    always @(negedge nclk) begin
        if (watch_en && rf_loaded && (rf_address_D == watch_addr)) begin
            raw_writes <= raw_writes + 1;
            if (rf_data_in !== rf[watch_addr]) change_writes <= change_writes + 1;
        end
    end

    task automatic tick();
        @(posedge nclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference behaviour: returns {carry, data}
    function automatic logic [8:0] modelExec(input int op, input int a, input int b, input int imm);
        int   r;
        logic c;
        c = 1'b0;
        case (op)
            0: begin r = a + b;   c = (r > 255); end
            1: begin r = a - b;   c = (a < b);   end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = a + imm; c = (r > 255); end
            6: r = imm;
            default: r = a;
        endcase
        r = r & 255;
        return {c, r[7:0]};
    endfunction

    task automatic checkRegFile(input string tag);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("%s_reg%0d", tag, i), rf[i], exp_rf[i]);
        end
    endtask

    // Run one full command with the response held back for 'hold' DONE cycles
    task automatic applyStimulus(input int op, input int rd, input int rs1, input int rs2,
                                 input int imm, input int hold, input string tag);
        logic [8:0] expv;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_wdata;
        logic [3:0] exp_waddr;
        int         n;
        logic       modifies;
        a = exp_rf[rs1];
        b = exp_rf[rs2];
        expv = modelExec(op, a, b, imm);
        exp_waddr = (op == 7) ? 4'(rs1) : 4'(rd);
        exp_wdata = (op == 7) ? a : expv[7:0];
        modifies  = (op != 7) && (exp_rf[rd] != expv[7:0]);

        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_ready_idle"}, cmd_ready, 1);

        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_rd    = 4'(rd);
        cmd_rs1   = 4'(rs1);
        cmd_rs2   = 4'(rs2);
        cmd_imm   = 8'(imm);
        rsp_ready = (hold == 0);
        tick();

        watch_addr = 4'(rd);
        raw_writes = 0;
        change_writes = 0;
        watch_en = 1'b1;
        cmd_valid = 1'b1;
        cmd_op  = 3'($urandom_range(0, 7));
        cmd_rd  = 4'($urandom_range(0, 15));
        cmd_rs1 = 4'($urandom_range(0, 15));
        cmd_rs2 = 4'($urandom_range(0, 15));
        cmd_imm = 8'($urandom_range(0, 255));
        checkOutput({tag, "_busy_read"}, busy, 1);
        checkOutput({tag, "_ready_read"}, cmd_ready, 0);
        checkOutput({tag, "_addrA"}, rf_address_A, rs1);
        checkOutput({tag, "_addrB"}, rf_address_B, rs2);
        checkOutput({tag, "_valid_read"}, rsp_valid, 0);

        tick();
        checkOutput({tag, "_valid_exec"}, rsp_valid, 0);

        tick();
        checkOutput({tag, "_valid_write"}, rsp_valid, 0);
        checkOutput({tag, "_addrD_write"}, rf_address_D, exp_waddr);
        checkOutput({tag, "_wdata"}, rf_data_in, exp_wdata);

        tick();
        checkOutput({tag, "_valid_done"}, rsp_valid, 1);
        checkOutput({tag, "_data"}, rsp_data, expv[7:0]);
        checkOutput({tag, "_carry"}, rsp_carry, expv[8]);
        checkOutput({tag, "_zero"}, rsp_zero, (expv[7:0] == 8'd0));
        checkOutput({tag, "_ready_done"}, cmd_ready, 0);

        for (int h = 0; h < hold; h++) begin
            tick();
            checkOutput({tag, "_hold_valid"}, rsp_valid, 1);
            checkOutput({tag, "_hold_data"}, rsp_data, expv[7:0]);
            checkOutput({tag, "_hold_carry"}, rsp_carry, expv[8]);
            checkOutput({tag, "_hold_ready"}, cmd_ready, 0);
        end

        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        watch_en = 1'b0;
        checkOutput({tag, "_valid_after"}, rsp_valid, 0);
        checkOutput({tag, "_busy_after"}, busy, 0);
        checkOutput({tag, "_ready_after"}, cmd_ready, 1);
        checkOutput({tag, "_changes"}, change_writes, modifies ? 1 : 0);

        if (op != 7) exp_rf[rd] = expv[7:0];
        checkRegFile(tag);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) exp_rf[i] = 8'(i);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd7;
        cmd_rd    = 4'd0;
        cmd_rs1   = 4'd0;
        cmd_rs2   = 4'd0;
        cmd_imm   = 8'd0;
        rsp_ready = 1'b0;

        $display("[TB] reset");
        tick();
        tick();
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        checkOutput("rst_addrD", rf_address_D, 0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_ready", cmd_ready, 1);
        checkRegFile("init");

        $display("[TB] directed commands");
        applyStimulus(0, 3, 1, 2, 0, 0, "add");
        applyStimulus(1, 4, 1, 2, 0, 0, "sub");
        applyStimulus(5, 15, 15, 0, 8'hF1, 0, "addi");
        applyStimulus(0, 0, 15, 15, 0, 0, "add_fwd");
        applyStimulus(6, 7, 0, 0, 8'hA5, 6, "ldi");
        checkOutput("ldi_raw_writes", raw_writes, 1);
        applyStimulus(7, 2, 9, 5, 8'h33, 0, "nop");

        $display("[TB] reset during write");
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_rd    = 4'd6;
        cmd_rs1   = 4'd1;
        cmd_rs2   = 4'd2;
        cmd_imm   = 8'd0;
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checkOutput("abort_busy", busy, 1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("abort_valid", rsp_valid, 0);
        checkOutput("abort_busy_rst", busy, 0);
        checkOutput("abort_ready", cmd_ready, 0);
        checkOutput("abort_addrA", rf_address_A, 0);
        checkOutput("abort_addrB", rf_address_B, 0);
        checkOutput("abort_addrD", rf_address_D, 0);
        checkOutput("abort_data", rsp_data, 0);
        checkOutput("abort_carry", rsp_carry, 0);
        checkOutput("abort_zero", rsp_zero, 0);
        checkOutput("abort_wdata", rf_data_in, rf[0]);
        tick();
        tick();
        checkOutput("abort_valid_held", rsp_valid, 0);
        rst = 1'b0;
        rsp_ready = 1'b0;
        tick();
        checkOutput("abort_ready_after", cmd_ready, 1);
        checkOutput("abort_valid_after", rsp_valid, 0);
        checkRegFile("abort");
        applyStimulus(2, 6, 6, 15, 0, 1, "after_abort");

        $display("[TB] random commands");
        for (int k = 0; k < 20; k++) begin
            applyStimulus($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
                          $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 2),
                          $sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
